// File: rtl/inst_fetch_resp_if.sv
// Fetch request / response bundle between the PC stage and inst_fetch_resp,
// including the program-load write port.
interface inst_fetch_resp_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  ce;
    logic [31:0]           addr;
    logic                  stall;
    logic                  ld_we;
    logic [DEPTH_LOG2-1:0] ld_addr;
    logic [31:0]           ld_data;
    logic [31:0]           inst;
    logic                  inst_valid;
    logic [31:0]           inst_addr;
    logic                  addr_err;

    modport master (
        output ce, addr, stall, ld_we, ld_addr, ld_data,
        input  inst, inst_valid, inst_addr, addr_err
    );

    modport slave (
        input  ce, addr, stall, ld_we, ld_addr, ld_data,
        output inst, inst_valid, inst_addr, addr_err
    );
endinterface

// File: rtl/inst_fetch_resp.sv
// Single-cycle instruction fetch responder with program-load port and IDLE/SERVE/HOLD FSM.
// Optional feature: define INST_FETCH_ALIGN_CHECK_EN to fault misaligned fetch addresses.
module inst_fetch_resp #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_resp_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [31:0]           r_mem [0:DEPTH-1];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [31:0]           r_inst;
    logic [31:0]           r_inst_addr;
    logic                  r_addr_err;
    logic                  r_inst_valid;
    logic [31:0]           w_inst_nxt;
    logic [31:0]           w_inst_addr_nxt;
    logic                  w_addr_err_nxt;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_rd_data;
    logic                  w_range_err;
    logic                  w_align_err;
    logic                  w_fault;

    assign w_idx       = bus.addr[DEPTH_LOG2+1:2];
    assign w_range_err = |bus.addr[31:DEPTH_LOG2+2];
`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign w_align_err = (bus.addr[1:0] != 2'b00);
`else
    assign w_align_err = 1'b0;
`endif
    assign w_fault = w_range_err | w_align_err;

    // A load landing on the word being fetched is forwarded so the fetch sees new data.
    assign w_rd_data = (bus.ld_we && (bus.ld_addr == w_idx)) ? bus.ld_data : r_mem[w_idx];

    // Program-load write port; deliberately untouched by reset and the FSM.
    always_ff @(posedge clk) begin
        if (bus.ld_we) begin
            r_mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next response; a stalled request is dropped, not queued.
    always_comb begin
        w_state_nxt     = r_state;
        w_inst_nxt      = r_inst;
        w_inst_addr_nxt = r_inst_addr;
        w_addr_err_nxt  = r_addr_err;
        if (bus.stall) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_IDLE;
                ST_SERVE: w_state_nxt = ST_HOLD;
                ST_HOLD:  w_state_nxt = ST_HOLD;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end else if (bus.ce) begin
            w_state_nxt     = ST_SERVE;
            w_inst_nxt      = w_fault ? 32'd0 : w_rd_data;
            w_inst_addr_nxt = bus.addr;
            w_addr_err_nxt  = w_fault;
        end else begin
            w_state_nxt     = ST_IDLE;
            w_inst_nxt      = 32'd0;
            w_inst_addr_nxt = 32'd0;
            w_addr_err_nxt  = 1'b0;
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst       <= 32'd0;
            r_inst_addr  <= 32'd0;
            r_addr_err   <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst       <= w_inst_nxt;
            r_inst_addr  <= w_inst_addr_nxt;
            r_addr_err   <= w_addr_err_nxt;
            r_inst_valid <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.inst       = r_inst;
    assign bus.inst_addr  = r_inst_addr;
    assign bus.addr_err   = r_addr_err;
    assign bus.inst_valid = r_inst_valid;
endmodule

// File: doc/inst_fetch_resp.md
INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Interface
REQ-001 Parameter: DEPTH_LOG2, default 10, log2 of instruction memory depth in 32-bit words.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ce  input  1  fetch request enable from the PC stage.
REQ-005 addr  input  32  byte address of the requested instruction.
REQ-006 stall  input  1  downstream hold; 1 = keep current outputs, ignore the request.
REQ-007 ld_we  input  1  program-load write enable.
REQ-008 ld_addr  input  DEPTH_LOG2  program-load word index.
REQ-009 ld_data  input  32  program-load write data.
REQ-010 inst  output  32  fetched instruction word.
REQ-011 inst_valid  output  1  inst/inst_addr/addr_err are meaningful this cycle.
REQ-012 inst_addr  output  32  byte address that produced the current inst.
REQ-013 addr_err  output  1  current response is an address fault; inst forced to 0.

Function
REQ-014 Storage SHALL be 2^DEPTH_LOG2 x 32-bit words; word index = addr[DEPTH_LOG2+1:2].
REQ-015 Read latency SHALL be exactly 1 cycle: request sampled with ce=1, stall=0 at edge N; response on outputs after edge N.
REQ-016 FSM states SHALL be IDLE (inst_valid=0), SERVE (fresh response presented), HOLD (response held under stall).
REQ-017 IDLE/SERVE/HOLD with stall=0, ce=1 -> SERVE; with stall=0, ce=0 -> IDLE, inst=0, inst_addr=0, addr_err=0.
REQ-018 SERVE or HOLD with stall=1 -> HOLD; inst, inst_addr, addr_err, inst_valid SHALL remain unchanged; the request is dropped, not queued.
REQ-019 IDLE with stall=1 SHALL remain IDLE with outputs unchanged.
REQ-020 Out of range (addr[31:DEPTH_LOG2+2] nonzero) SHALL produce inst=0, addr_err=1, inst_valid=1, inst_addr=addr.
REQ-021 ld_we=1 SHALL write ld_data to mem[ld_addr] at the edge, independent of ce, stall and FSM state.
REQ-022 Same-edge load and read of the same index SHALL return ld_data (write-through bypass); different index returns stored data.
REQ-023 addr wraps only through the range check; no modular aliasing of high address bits.
REQ-024 Memory contents SHALL NOT be initialised by the block; unloaded words read as whatever the array holds.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, inst=0, inst_valid=0, inst_addr=0, addr_err=0, overriding ce, stall and any in-flight request.
REQ-026 Reset SHALL NOT alter memory contents; ld_we writes during reset SHALL still take effect.
REQ-027 First response after reset release SHALL appear one cycle after the first edge sampling rst=0, ce=1, stall=0.

Configuration
REQ-028 Macro INST_FETCH_ALIGN_CHECK_EN defined: addr[1:0] != 0 SHALL produce inst=0, addr_err=1, inst_valid=1, inst_addr=addr; alignment fault takes precedence over the range check.
REQ-029 Macro INST_FETCH_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored, and addr_err SHALL reflect only the range check.

Verification
REQ-030 Load mem[0..3]=0x11111111..0x44444444; fetch addr 0,4,8,12 back-to-back -> inst 0x11111111..0x44444444, each one cycle after its request, inst_valid=1.
REQ-031 Fetch addr 0x8 then stall=1 for 3 cycles while addr=0xC -> inst holds 0x33333333, inst_addr=0x8; after release, addr 0xC -> 0x44444444 next cycle.
REQ-032 Same cycle ld_we=1, ld_addr=5, ld_data=0xDEADBEEF and fetch addr 0x14 -> next cycle inst=0xDEADBEEF.
REQ-033 DEPTH_LOG2=10, fetch addr 0x1000 -> inst=0, addr_err=1, inst_valid=1; with INST_FETCH_ALIGN_CHECK_EN, fetch addr 0x6 -> addr_err=1, and without it -> inst=mem[1], addr_err=0.
REQ-034 Assert rst during HOLD -> next cycle all outputs 0; fetch addr 0x0 after release -> previously loaded 0x11111111 returned.
